int_sched: RTL and testbench



---
 rtl/int_sched_pkg.sv | 27 ++
 rtl/int_sched_if.sv | 31 +++
 rtl/int_sched_epc_stack.sv | 48 ++++
 rtl/int_sched.sv | 105 ++++++++++
 tb/tb_int_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/int_sched_pkg.sv
// Shared definitions for the interrupt scheduler: FSM encoding, vector defaults
// and the lowest-set-bit priority helper.
package int_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_2000;
  localparam int          VEC_SHIFT_DEF = 4;

  // Index of the lowest set bit (0 when the vector is empty); lower index = higher priority.
  function automatic logic [4:0] lowest_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_sched_if.sv
// Pipeline-side bundle of the interrupt scheduler: irq/mask inputs, EX-stage
// handshake, next-PC override and status outputs.
interface int_sched_if #(
  parameter int N_IRQ = 3
);
  localparam int DW = $clog2(N_IRQ + 1);

  logic [N_IRQ-1:0] irq;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             accept_ok;
  logic [31:0]      resume_pc;
  logic             eret;
  logic             int_request;
  logic [31:0]      int_next_pc;
  logic             flush;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] in_service;
  logic [DW-1:0]    depth;

  modport master (
    output irq, mask_we, mask_wdata, accept_ok, resume_pc, eret,
    input  int_request, int_next_pc, flush, pending, in_service, depth
  );

  modport slave (
    input  irq, mask_we, mask_wdata, accept_ok, resume_pc, eret,
    output int_request, int_next_pc, flush, pending, in_service, depth
  );

endinterface

// File: rtl/int_sched_epc_stack.sv
// LIFO of resume PCs, one entry per nesting level; push and pop never coincide.
module int_sched_epc_stack #(
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   top,
  output logic [CW-1:0] count
);
  import int_sched_pkg::*;

  logic [31:0]   mem_r [DEPTH];
  logic [CW-1:0] count_r;
  logic [CW-1:0] top_pos_s;

  // Top-of-stack read, zero when empty.
  always_comb begin
    top_pos_s = count_r - CW'(1);
    if (count_r != '0) begin
      top = mem_r[top_pos_s[IW-1:0]];
    end else begin
      top = 32'd0;
    end
  end

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (push) begin
      mem_r[count_r[IW-1:0]] <= din;
      count_r                <= count_r + CW'(1);
    end else if (pop) begin
      count_r <= count_r - CW'(1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/int_sched.sv
// Nested priority interrupt scheduler driving the EX-stage next-PC override,
// the IF/ID flush and an EPC stack for ERET.
module int_sched
  import int_sched_pkg::*;
#(
  parameter int          N_IRQ     = 3,
  parameter logic [31:0] VEC_BASE  = VEC_BASE_DEF,
  parameter int          VEC_SHIFT = VEC_SHIFT_DEF
) (
  input logic        clk,
  input logic        rst_n,
  int_sched_if.slave bus
);
  localparam int DW = $clog2(N_IRQ + 1);

  logic [N_IRQ-1:0] sync1_r, sync2_r, prev_r;
  logic [N_IRQ-1:0] pending_r, in_service_r, mask_r;
  sched_state_e     state_r;

  logic [N_IRQ-1:0] edge_s, above_s, eligible_s, win_oh_s, svc_oh_s;
  logic [4:0]       svc_idx_s, win_idx_s;
  logic             eret_fire_s, entry_fire_s;
  logic [31:0]      top_s, next_pc_s;
  logic [DW-1:0]    depth_s;

  // Priority resolution and redirect decision for the current EX cycle.
  always_comb begin
    edge_s    = sync2_r & ~prev_r;
    svc_idx_s = lowest_index(32'(in_service_r));
    for (int i = 0; i < N_IRQ; i++) begin
      above_s[i]  = (in_service_r == '0) || (5'(i) < svc_idx_s);
      svc_oh_s[i] = (5'(i) == svc_idx_s);
    end
    eligible_s = pending_r & mask_r & above_s;
    win_idx_s  = lowest_index(32'(eligible_s));
    for (int i = 0; i < N_IRQ; i++) begin
      win_oh_s[i] = (5'(i) == win_idx_s);
    end
    // ERET outranks entry; an entry seen in the same cycle waits for the next IDLE.
    eret_fire_s  = (state_r == IDLE) && bus.eret && (depth_s != '0);
    entry_fire_s = (state_r == IDLE) && !eret_fire_s && (eligible_s != '0) && bus.accept_ok;
    if (eret_fire_s) begin
      next_pc_s = top_s;
    end else if (entry_fire_s) begin
      next_pc_s = VEC_BASE + (32'(win_idx_s) << VEC_SHIFT);
    end else begin
      next_pc_s = 32'd0;
    end
  end

  // Edge capture, mask, pending/in-service bookkeeping and the IDLE/HOLD FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r      <= '0;
      sync2_r      <= '0;
      prev_r       <= '0;
      mask_r       <= '1;
      pending_r    <= '0;
      in_service_r <= '0;
      state_r      <= IDLE;
    end else begin
      sync1_r <= bus.irq;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      mask_r  <= bus.mask_we ? bus.mask_wdata : mask_r;
      // A fresh edge on the winner re-arms it even while it is being taken.
      pending_r <= (pending_r & ~(entry_fire_s ? win_oh_s : '0)) | edge_s;
      case (state_r)
        IDLE: begin
          if (eret_fire_s) begin
            in_service_r <= in_service_r & ~svc_oh_s;
            state_r      <= HOLD;
          end else if (entry_fire_s) begin
            in_service_r <= in_service_r | win_oh_s;
            state_r      <= HOLD;
          end else begin
            state_r <= IDLE;
          end
        end
        HOLD:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  int_sched_epc_stack #(
    .DEPTH (N_IRQ)
  ) u_epc_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (entry_fire_s),
    .pop   (eret_fire_s),
    .din   (bus.resume_pc),
    .top   (top_s),
    .count (depth_s)
  );

  assign bus.int_request = eret_fire_s | entry_fire_s;
  assign bus.flush       = eret_fire_s | entry_fire_s;
  assign bus.int_next_pc = next_pc_s;
  assign bus.pending     = pending_r;
  assign bus.in_service  = in_service_r;
  assign bus.depth       = depth_s;

endmodule

// File: tb/tb_int_sched.sv
// Directed plus randomized bench for int_sched, checked every cycle against a
// queue-based reference model of the scheduling rules.
module tb_int_sched;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int_sched_if #(.N_IRQ(N)) bus ();

  int_sched #(
    .N_IRQ     (N),
    .VEC_BASE  (32'h0000_2000),
    .VEC_SHIFT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit [N-1:0]  m_pend;
  bit [N-1:0]  m_mask;
  bit          m_hold;
  int          m_svc[$];
  logic [31:0] m_epc[$];
  bit [N-1:0]  m_hist[$];

  logic        obs_req;
  logic [31:0] obs_pc;
  logic [N-1:0] obs_pend, obs_svc;
  logic [1:0]  obs_depth;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_mask = '1;
    m_hold = 1'b0;
    m_svc.delete();
    m_epc.delete();
    m_hist.delete();
    repeat (3) m_hist.push_back('0);
  endtask

  function automatic int svc_min();
    int m = N;
    foreach (m_svc[i]) if (m_svc[i] < m) m = m_svc[i];
    return m;
  endfunction

  function automatic bit [N-1:0] svc_bits();
    bit [N-1:0] b = '0;
    foreach (m_svc[i]) b[m_svc[i]] = 1'b1;
    return b;
  endfunction

  // kind: 0 none, 1 eret, 2 entry
  task automatic model_decide(output bit req, output logic [31:0] pc, output int kind, output int src);
    req = 1'b0; pc = 32'd0; kind = 0; src = 0;
    if (!m_hold && bus.eret && m_epc.size() > 0) begin
      kind = 1; req = 1'b1; pc = m_epc[m_epc.size()-1];
    end else if (!m_hold && bus.accept_ok) begin
      int lim = svc_min();
      for (int i = N - 1; i >= 0; i--) begin
        if (i < lim && m_pend[i] && m_mask[i]) begin
          src = i; kind = 2;
        end
      end
      if (kind == 2) begin
        req = 1'b1; pc = 32'h0000_2000 + (32'(src) << 4);
      end
    end
  endtask

  task automatic cycle();
    bit          er;
    logic [31:0] epc;
    int          kind, src;
    bit [N-1:0]  edge_v;
    @(negedge clk);
    model_decide(er, epc, kind, src);
    check("int_request", 32'(bus.int_request), 32'(er));
    check("int_next_pc", bus.int_next_pc, epc);
    check("flush", 32'(bus.flush), 32'(er));
    check("pending", 32'(bus.pending), 32'(m_pend));
    check("in_service", 32'(bus.in_service), 32'(svc_bits()));
    check("depth", 32'(bus.depth), 32'(m_epc.size()));
    obs_req = bus.int_request; obs_pc = bus.int_next_pc;
    obs_pend = bus.pending; obs_svc = bus.in_service; obs_depth = bus.depth;
    @(posedge clk);
    m_hist.push_back(bus.irq);
    edge_v = m_hist[m_hist.size()-3] & ~m_hist[m_hist.size()-4];
    m_hold = (kind != 0);
    if (kind == 2) begin
      m_pend[src] = 1'b0;
      m_svc.push_back(src);
      m_epc.push_back(bus.resume_pc);
    end else if (kind == 1) begin
      void'(m_svc.pop_back());
      void'(m_epc.pop_back());
    end
    m_pend = m_pend | edge_v;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.irq = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.accept_ok = 1'b0; bus.resume_pc = 32'd0; bus.eret = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // basic entry / return
    bus.accept_ok = 1'b1; bus.resume_pc = 32'h0040_0010; bus.irq = 3'b010;
    repeat (3) cycle();
    cycle();
    check("t1_entry_req", 32'(obs_req), 32'd1);
    check("t1_entry_pc", obs_pc, 32'h0000_2010);
    cycle();
    check("t1_svc", 32'(obs_svc), 32'd2);
    check("t1_depth", 32'(obs_depth), 32'd1);
    bus.eret = 1'b1; cycle();
    check("t1_eret_pc", obs_pc, 32'h0040_0010);
    bus.eret = 1'b0; cycle();
    check("t1_svc_after", 32'(obs_svc), 32'd0);

    // nesting and preemption
    bus.irq = 3'b000; repeat (2) cycle();
    bus.irq = 3'b010; bus.resume_pc = 32'h0040_0100; repeat (5) cycle();
    bus.irq = 3'b110; bus.resume_pc = 32'h0040_0200; repeat (6) cycle();
    check("t2_irq2_blocked", 32'(obs_req), 32'd0);
    check("t2_irq2_pending", 32'(obs_pend), 32'd4);
    bus.irq = 3'b111; bus.resume_pc = 32'h0040_0300; repeat (3) cycle();
    cycle();
    check("t2_irq0_pc", obs_pc, 32'h0000_2000);
    cycle();
    check("t2_depth2", 32'(obs_depth), 32'd2);
    bus.eret = 1'b1; cycle();
    check("t2_eret1_pc", obs_pc, 32'h0040_0300);
    bus.eret = 1'b0; cycle();
    bus.eret = 1'b1; cycle();
    check("t2_eret2_pc", obs_pc, 32'h0040_0100);
    bus.eret = 1'b0; cycle();
    cycle();
    check("t2_irq2_pc", obs_pc, 32'h0000_2020);
    cycle();
    bus.eret = 1'b1; cycle();
    bus.eret = 1'b0; cycle();
    bus.irq = 3'b000; repeat (2) cycle();

    // accept_ok gating
    bus.accept_ok = 1'b0; bus.irq = 3'b001; repeat (3) cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t3_gated", 32'(obs_req), 32'd0);
    end
    bus.accept_ok = 1'b1; cycle();
    check("t3_open_pc", obs_pc, 32'h0000_2000);
    cycle();
    bus.eret = 1'b1; cycle();
    bus.eret = 1'b0; cycle();
    bus.irq = 3'b000; repeat (2) cycle();

    // mask
    bus.mask_we = 1'b1; bus.mask_wdata = 3'b110; cycle();
    bus.mask_we = 1'b0; bus.irq = 3'b001; repeat (5) cycle();
    check("t4_masked_pend", 32'(obs_pend), 32'd1);
    check("t4_masked_req", 32'(obs_req), 32'd0);
    bus.mask_we = 1'b1; bus.mask_wdata = 3'b111; cycle();
    check("t4_write_cycle", 32'(obs_req), 32'd0);
    bus.mask_we = 1'b0; cycle();
    check("t4_unmask_pc", obs_pc, 32'h0000_2000);
    cycle();
    bus.eret = 1'b1; cycle();
    bus.eret = 1'b0; cycle();
    bus.irq = 3'b000; repeat (2) cycle();

    // simultaneous eret and entry; eret at depth 0
    bus.irq = 3'b010; bus.resume_pc = 32'h0040_0500; repeat (5) cycle();
    bus.accept_ok = 1'b0; bus.irq = 3'b011; repeat (4) cycle();
    check("t5_pend0", 32'(obs_pend), 32'd1);
    bus.eret = 1'b1; bus.accept_ok = 1'b1; cycle();
    check("t5_eret_first", obs_pc, 32'h0040_0500);
    bus.eret = 1'b0; cycle();
    check("t5_hold", 32'(obs_req), 32'd0);
    cycle();
    check("t5_entry_after", obs_pc, 32'h0000_2000);
    cycle();
    bus.eret = 1'b1; cycle();
    bus.eret = 1'b0; cycle();
    bus.eret = 1'b1; cycle();
    check("t5_eret_empty", 32'(obs_req), 32'd0);
    bus.eret = 1'b0; cycle();
    bus.irq = 3'b000; repeat (2) cycle();

    // asynchronous reset mid-operation
    bus.irq = 3'b010; bus.resume_pc = 32'h0040_0600; repeat (5) cycle();
    bus.irq = 3'b111; repeat (5) cycle();
    check("t6_depth", 32'(obs_depth), 32'd2);
    check("t6_pend", 32'(obs_pend), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(bus.int_request), 32'd0);
    check("t6_rst_pc", bus.int_next_pc, 32'd0);
    check("t6_rst_flush", 32'(bus.flush), 32'd0);
    check("t6_rst_pend", 32'(bus.pending), 32'd0);
    check("t6_rst_svc", 32'(bus.in_service), 32'd0);
    check("t6_rst_depth", 32'(bus.depth), 32'd0);
    model_reset();
    bus.irq = 3'b000;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) bus.irq = bus.irq ^ 3'($urandom_range(1, 7));
      bus.accept_ok  = ($urandom_range(0, 3) != 0);
      bus.eret       = ($urandom_range(0, 4) == 0);
      bus.mask_we    = ($urandom_range(0, 19) == 0);
      bus.mask_wdata = 3'($urandom);
      bus.resume_pc  = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
